// File: rtl/dma_w_burst_if.sv
// Bus bundle for dma_w_burst: upstream beat handshake (dma_w_*) and the
// AXI4 write channels (m_axi_aw*/w*/b*).
// master: the burst engine's view. slave: the surrounding environment's view.
interface dma_w_burst_if #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int AXI_LEN_W = 8
);
  logic                   dma_w_valid;
  logic [ADDR_W-1:0]      dma_w_addr;
  logic [DATA_W-1:0]      dma_w_wdata;
  logic [DATA_W/8-1:0]    dma_w_wstrb;
  logic [AXI_LEN_W-1:0]   dma_w_len;
  logic                   dma_w_ready;

  logic [ADDR_W-1:0]      m_axi_awaddr;
  logic [AXI_LEN_W-1:0]   m_axi_awlen;
  logic [2:0]             m_axi_awsize;
  logic [1:0]             m_axi_awburst;
  logic                   m_axi_awvalid;
  logic                   m_axi_awready;
  logic [DATA_W-1:0]      m_axi_wdata;
  logic [DATA_W/8-1:0]    m_axi_wstrb;
  logic                   m_axi_wlast;
  logic                   m_axi_wvalid;
  logic                   m_axi_wready;
  logic [1:0]             m_axi_bresp;
  logic                   m_axi_bvalid;
  logic                   m_axi_bready;

  modport master (
    input  dma_w_valid, dma_w_addr, dma_w_wdata, dma_w_wstrb, dma_w_len,
    output dma_w_ready,
    output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    output dma_w_valid, dma_w_addr, dma_w_wdata, dma_w_wstrb, dma_w_len,
    input  dma_w_ready,
    input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );
endinterface

// File: rtl/dma_w_burst.sv
// AXI4 write-burst master fed by the DMA write-data aligner.
// One burst per request: AW beat, W beats ending in WLAST, then B collection.
// Optional feature macro: DMA_W_BURST_SKID_EN
//   undefined: W channel is a combinational pass-through of the upstream beat.
//   defined:   W channel is fed from a 2-entry skid buffer (registered outputs,
//              one cycle of added latency, upstream isolated from wready).
//
// state   | meaning
// IDLE    | waiting for the first upstream beat; latches address and length
// ADDR    | AW presented, held until awready
// DATA    | streaming W beats, cnt counts remaining beats (0 = last)
// RESP    | bready high, waiting for the B response
module dma_w_burst #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int AXI_LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  dma_w_burst_if.master    bus,
  output logic             busy_o,
  output logic             error_o,
  output logic [1:0]       last_bresp_o
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      awaddr_q, awaddr_d;
  logic [AXI_LEN_W-1:0]   awlen_q, awlen_d;
  logic [AXI_LEN_W-1:0]   cnt_q, cnt_d;
  logic                   error_q, error_d;
  logic [1:0]             last_bresp_q, last_bresp_d;
  logic                   aw_valid;
  logic                   b_ready;
  logic                   in_data;
  logic                   w_hs;
  logic                   beat_take;
  logic                   data_done;

  assign in_data = (state_q == ST_DATA);
  assign w_hs    = bus.m_axi_wvalid && bus.m_axi_wready;

`ifdef DMA_W_BURST_SKID_EN
  logic [DATA_W-1:0] mem_data_q [2];
  logic [STRB_W-1:0] mem_strb_q [2];
  logic              mem_last_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        fill_q;
  logic              all_in_q;
  logic              up_ready;
  logic              up_acc;

  // all_in_q stops intake once the last beat of the burst has been taken
  assign up_ready  = in_data && !all_in_q && (fill_q != 2'd2);
  assign up_acc    = up_ready && bus.dma_w_valid;
  assign beat_take = up_acc;
  assign data_done = w_hs && bus.m_axi_wlast;

  assign bus.dma_w_ready  = up_ready;
  assign bus.m_axi_wvalid = (fill_q != 2'd0);
  assign bus.m_axi_wdata  = mem_data_q[rd_ptr_q];
  assign bus.m_axi_wstrb  = mem_strb_q[rd_ptr_q];
  assign bus.m_axi_wlast  = (fill_q != 2'd0) && mem_last_q[rd_ptr_q];

  // skid buffer storage; contents are don't-care while the fill count is zero
  always_ff @(posedge clk_i) begin
    if (up_acc) begin
      mem_data_q[wr_ptr_q] <= bus.dma_w_wdata;
      mem_strb_q[wr_ptr_q] <= bus.dma_w_wstrb;
      mem_last_q[wr_ptr_q] <= (cnt_q == '0);
    end
  end

  // skid buffer pointers, fill level and end-of-burst intake flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      fill_q   <= 2'd0;
      all_in_q <= 1'b0;
    end else begin
      if (up_acc) wr_ptr_q <= ~wr_ptr_q;
      if (w_hs)   rd_ptr_q <= ~rd_ptr_q;
      fill_q <= fill_q + 2'(up_acc) - 2'(w_hs);
      if (!in_data)
        all_in_q <= 1'b0;
      else if (up_acc && (cnt_q == '0))
        all_in_q <= 1'b1;
    end
  end
`else
  assign beat_take = w_hs;
  assign data_done = w_hs && (cnt_q == '0);

  assign bus.dma_w_ready  = in_data && bus.m_axi_wready;
  assign bus.m_axi_wvalid = in_data && bus.dma_w_valid;
  assign bus.m_axi_wdata  = bus.dma_w_wdata;
  assign bus.m_axi_wstrb  = bus.dma_w_wstrb;
  assign bus.m_axi_wlast  = in_data && (cnt_q == '0);
`endif

  // next-state and burst bookkeeping; a B response in the same cycle as
  // clear takes precedence so a fresh failure is never lost
  always_comb begin
    state_d      = state_q;
    awaddr_d     = awaddr_q;
    awlen_d      = awlen_q;
    cnt_d        = cnt_q;
    error_d      = clear_i ? 1'b0 : error_q;
    last_bresp_d = clear_i ? 2'b00 : last_bresp_q;
    aw_valid     = 1'b0;
    b_ready      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.dma_w_valid) begin
          awaddr_d = bus.dma_w_addr;
          awlen_d  = bus.dma_w_len;
          cnt_d    = bus.dma_w_len;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        aw_valid = 1'b1;
        if (bus.m_axi_awready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (beat_take && (cnt_q != '0)) cnt_d = cnt_q - AXI_LEN_W'(1);
        if (data_done) state_d = ST_RESP;
      end
      ST_RESP: begin
        b_ready = 1'b1;
        if (bus.m_axi_bvalid) begin
          last_bresp_d = bus.m_axi_bresp;
          error_d      = error_d | (bus.m_axi_bresp != 2'b00);
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and status registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      awaddr_q     <= '0;
      awlen_q      <= '0;
      cnt_q        <= '0;
      error_q      <= 1'b0;
      last_bresp_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      awaddr_q     <= awaddr_d;
      awlen_q      <= awlen_d;
      cnt_q        <= cnt_d;
      error_q      <= error_d;
      last_bresp_q <= last_bresp_d;
    end
  end

  assign bus.m_axi_awaddr  = awaddr_q;
  assign bus.m_axi_awlen   = awlen_q;
  assign bus.m_axi_awsize  = 3'($clog2(STRB_W));
  assign bus.m_axi_awburst = 2'b01;
  assign bus.m_axi_awvalid = aw_valid;
  assign bus.m_axi_bready  = b_ready;

  assign busy_o       = (state_q != ST_IDLE);
  assign error_o      = error_q;
  assign last_bresp_o = last_bresp_q;

endmodule

// File: tb/tb_dma_w_burst.sv
// Scoreboard bench for dma_w_burst: the driver pushes expected AW/W beats,
// a negedge monitor pops and compares on every handshake.
module tb_dma_w_burst;

`ifdef DMA_W_BURST_SKID_EN
  localparam int FIRST_W_LAT = 2;
`else
  localparam int FIRST_W_LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       busy;
  logic       error;
  logic [1:0] last_bresp;

  dma_w_burst_if #(.ADDR_W(32), .DATA_W(32), .AXI_LEN_W(8)) bus_if ();

  dma_w_burst #(.ADDR_W(32), .DATA_W(32), .AXI_LEN_W(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (clear),
    .bus          (bus_if),
    .busy_o       (busy),
    .error_o      (error),
    .last_bresp_o (last_bresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } wexp_t;
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } awexp_t;

  wexp_t  w_q [$];
  awexp_t aw_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wready_mode = 0;
  int aw_delay = 0;
  int aw_wait = 0;
  logic [1:0] cur_bresp = 2'b00;
  logic aw_done = 1'b0;
  logic aw_pend = 1'b0;
  logic [31:0] aw_prev_addr = '0;
  logic [7:0]  aw_prev_len = '0;
  int aw_hs_cyc = 0;
  logic first_w_seen = 1'b1;
  logic tog = 1'b1;
  wexp_t  we;
  awexp_t ae;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // W ready pattern: 0 always ready, 1 toggling, 2 random
  initial begin
    bus_if.m_axi_wready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (wready_mode)
        1: begin bus_if.m_axi_wready = tog; tog = ~tog; end
        2: bus_if.m_axi_wready = 1'($urandom_range(0, 1));
        default: bus_if.m_axi_wready = 1'b1;
      endcase
    end
  end

  // AW ready after aw_delay cycles of awvalid
  initial begin
    bus_if.m_axi_awready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus_if.m_axi_awvalid) begin
        if (aw_wait >= aw_delay) bus_if.m_axi_awready = 1'b1;
        else begin bus_if.m_axi_awready = 1'b0; aw_wait++; end
      end else begin
        bus_if.m_axi_awready = 1'b0;
        aw_wait = 0;
      end
    end
  end

  // B responder: answers one cycle after the WLAST handshake
  initial begin
    logic bh, wl;
    bus_if.m_axi_bvalid = 1'b0;
    bus_if.m_axi_bresp  = 2'b00;
    forever begin
      @(negedge clk);
      bh = bus_if.m_axi_bvalid && bus_if.m_axi_bready;
      wl = bus_if.m_axi_wvalid && bus_if.m_axi_wready && bus_if.m_axi_wlast;
      @(posedge clk); #1;
      if (bh) bus_if.m_axi_bvalid = 1'b0;
      if (wl) begin
        bus_if.m_axi_bvalid = 1'b1;
        bus_if.m_axi_bresp  = cur_bresp;
      end
    end
  end

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (aw_pend) begin
          check("aw_hold_valid", 64'(bus_if.m_axi_awvalid), 64'd1);
          check("aw_hold_addr", 64'(bus_if.m_axi_awaddr), 64'(aw_prev_addr));
          check("aw_hold_len", 64'(bus_if.m_axi_awlen), 64'(aw_prev_len));
        end
        if (bus_if.m_axi_awvalid)
          check("dma_ready_during_aw", 64'(bus_if.dma_w_ready), 64'd0);
        if (bus_if.m_axi_wvalid)
          check("w_after_aw", 64'(aw_done), 64'd1);
`ifndef DMA_W_BURST_SKID_EN
        if (bus_if.m_axi_wvalid)
          check("dma_ready_mirror", 64'(bus_if.dma_w_ready), 64'(bus_if.m_axi_wready));
`endif
        if (bus_if.m_axi_wvalid && !first_w_seen) begin
          first_w_seen = 1'b1;
          check("first_w_latency", 64'(cyc - aw_hs_cyc), 64'(FIRST_W_LAT));
        end
        if (bus_if.m_axi_awvalid && bus_if.m_axi_awready) begin
          check("aw_expected", 64'(aw_q.size() != 0), 64'd1);
          if (aw_q.size() != 0) begin
            ae = aw_q.pop_front();
            check("awaddr", 64'(bus_if.m_axi_awaddr), 64'(ae.addr));
            check("awlen", 64'(bus_if.m_axi_awlen), 64'(ae.len));
            check("awsize", 64'(bus_if.m_axi_awsize), 64'd2);
            check("awburst", 64'(bus_if.m_axi_awburst), 64'd1);
          end
          aw_done = 1'b1;
          aw_hs_cyc = cyc;
          first_w_seen = 1'b0;
        end
        if (bus_if.m_axi_wvalid && bus_if.m_axi_wready) begin
          check("w_expected", 64'(w_q.size() != 0), 64'd1);
          if (w_q.size() != 0) begin
            we = w_q.pop_front();
            check("wdata", 64'(bus_if.m_axi_wdata), 64'(we.data));
            check("wstrb", 64'(bus_if.m_axi_wstrb), 64'(we.strb));
            check("wlast", 64'(bus_if.m_axi_wlast), 64'(we.last));
          end
          if (bus_if.m_axi_wlast) aw_done = 1'b0;
        end
        aw_pend      = bus_if.m_axi_awvalid && !bus_if.m_axi_awready;
        aw_prev_addr = bus_if.m_axi_awaddr;
        aw_prev_len  = bus_if.m_axi_awlen;
      end
    end
  end

  function automatic logic [31:0] beat_data(input logic [31:0] base, input int i);
    return base ^ (32'(i) * 32'h0001_0011);
  endfunction

  function automatic logic [3:0] beat_strb(input int i);
    logic [3:0] full;
    full = 4'hF;
    return full >> (i % 4);
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_awvalid"}, 64'(bus_if.m_axi_awvalid), 64'd0);
    check({tag, "_wvalid"}, 64'(bus_if.m_axi_wvalid), 64'd0);
    check({tag, "_wlast"}, 64'(bus_if.m_axi_wlast), 64'd0);
    check({tag, "_bready"}, 64'(bus_if.m_axi_bready), 64'd0);
    check({tag, "_dma_ready"}, 64'(bus_if.dma_w_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_last_bresp"}, 64'(last_bresp), 64'd0);
    check({tag, "_awaddr"}, 64'(bus_if.m_axi_awaddr), 64'd0);
    check({tag, "_awlen"}, 64'(bus_if.m_axi_awlen), 64'd0);
  endtask

  // drives one burst; abort_at >= 0 pulses rst after that many beats were accepted
  task automatic send_burst(input logic [31:0] addr, input int len, input logic [31:0] base,
                            input bit gaps, input int abort_at);
    awexp_t a;
    wexp_t  w;
    bit acc;
    int budget;
    a.addr = addr;
    a.len  = 8'(len);
    aw_q.push_back(a);
    for (int i = 0; i <= len; i++) begin
      w.data = beat_data(base, i);
      w.strb = beat_strb(i);
      w.last = (i == len);
      w_q.push_back(w);
    end
    bus_if.dma_w_addr = addr;
    bus_if.dma_w_len  = 8'(len);
    for (int i = 0; i <= len; i++) begin
      if (abort_at >= 0 && i == abort_at) begin
        rst = 1'b1;
        bus_if.dma_w_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_vals("midburst_rst");
        w_q.delete();
        aw_q.delete();
        aw_done = 1'b0;
        aw_pend = 1'b0;
        first_w_seen = 1'b1;
        return;
      end
      if (gaps && (i % 3 == 1)) begin
        bus_if.dma_w_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus_if.dma_w_valid = 1'b1;
      bus_if.dma_w_wdata = beat_data(base, i);
      bus_if.dma_w_wstrb = beat_strb(i);
      budget = 0;
      acc = 1'b0;
      while (!acc && budget < 2000) begin
        @(negedge clk);
        acc = bus_if.dma_w_ready && bus_if.dma_w_valid;
        @(posedge clk); #1;
        budget++;
      end
      if (!acc) begin
        check("beat_accept_timeout", 64'(budget), 64'd0);
        bus_if.dma_w_valid = 1'b0;
        return;
      end
    end
    bus_if.dma_w_valid = 1'b0;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (busy && budget < 500);
    check("burst_done_in_time", 64'(busy), 64'd0);
    check("queues_drained", 64'(w_q.size() + aw_q.size()), 64'd0);
  endtask

  initial begin
    bus_if.dma_w_valid = 1'b0;
    bus_if.dma_w_addr  = '0;
    bus_if.dma_w_len   = '0;
    bus_if.dma_w_wdata = '0;
    bus_if.dma_w_wstrb = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("por");

    // 1: single beat
    wready_mode = 0; aw_delay = 0; cur_bresp = 2'b00;
    @(posedge clk); #1;
    send_burst(32'h0000_0100, 0, 32'hA5A5_A5A5, 1'b0, -1);
    check("t1_error", 64'(error), 64'd0);
    check("t1_last_bresp", 64'(last_bresp), 64'd0);

    // 2: four beats, toggling wready
    wready_mode = 1;
    @(posedge clk); #1;
    send_burst(32'h0000_2000, 3, 32'hD000_0000, 1'b0, -1);

    // 3: AW stalled five cycles
    wready_mode = 0; aw_delay = 5;
    @(posedge clk); #1;
    send_burst(32'h0000_3000, 2, 32'h3333_0000, 1'b0, -1);
    aw_delay = 0;

    // 4: SLVERR then OKAY, clear with a same-cycle failure, then clear alone
    cur_bresp = 2'b10;
    @(posedge clk); #1;
    send_burst(32'h0000_4000, 1, 32'h4444_0000, 1'b0, -1);
    check("t4a_error", 64'(error), 64'd1);
    check("t4a_last_bresp", 64'(last_bresp), 64'd2);
    cur_bresp = 2'b00;
    @(posedge clk); #1;
    send_burst(32'h0000_4100, 1, 32'h4545_0000, 1'b0, -1);
    check("t4b_error_sticky", 64'(error), 64'd1);
    check("t4b_last_bresp", 64'(last_bresp), 64'd0);
    cur_bresp = 2'b11;
    @(posedge clk); #1;
    clear = 1'b1;
    send_burst(32'h0000_4200, 0, 32'h4646_0000, 1'b0, -1);
    check("t4c_fail_beats_clear", 64'(error), 64'd1);
    check("t4c_last_bresp", 64'(last_bresp), 64'd3);
    @(posedge clk); #1;
    clear = 1'b0;
    check("t4d_cleared_error", 64'(error), 64'd0);
    check("t4d_cleared_bresp", 64'(last_bresp), 64'd0);
    cur_bresp = 2'b00;

    // 5: reset during beat 2 of an 8-beat burst, then a clean burst
    @(posedge clk); #1;
    send_burst(32'h0000_5000, 7, 32'h5555_0000, 1'b0, 2);
    repeat (2) @(posedge clk);
    #1;
    send_burst(32'h0000_5100, 1, 32'h5656_0000, 1'b0, -1);
    check("t5_error_after", 64'(error), 64'd0);

    // 6: 256 beats, random wready, upstream gaps
    wready_mode = 2;
    @(posedge clk); #1;
    send_burst(32'h0000_6000, 255, 32'h6000_0000, 1'b1, -1);
    check("t6_error", 64'(error), 64'd0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
